// File: rtl/uart_cmd_deframer_if.sv
// uart_cmd_deframer_if
//   Bundles the UART byte strobe, the frame valid/ready handshake and the
//   error/overrun flags of uart_cmd_deframer.
//   Signals:
//     i_Rx_DV, i_Rx_Byte : byte strobe and data from the UART receiver
//     o_Frame_Valid      : held frame available, i_Frame_Ready accepts it
//     o_Cmd, o_Len       : command and payload length of the held frame
//     o_Payload          : payload, byte k at [8k+7:8k], unused bytes zero
//     o_Frame_Err        : one-cycle pulse, frame discarded, cause in o_Err_Code
//     o_Overrun          : one-cycle pulse, byte dropped while a frame is held
//   Modports:
//     slave  : deframer view (consumes bytes/ready, drives frame and flags)
//     master : surrounding logic view (drives bytes/ready, observes frame)
interface uart_cmd_deframer_if #(
  parameter int MAX_PAYLOAD = 16
);
  logic                     i_Rx_DV;
  logic [7:0]               i_Rx_Byte;
  logic                     o_Frame_Valid;
  logic                     i_Frame_Ready;
  logic [7:0]               o_Cmd;
  logic [7:0]               o_Len;
  logic [8*MAX_PAYLOAD-1:0] o_Payload;
  logic                     o_Frame_Err;
  logic [1:0]               o_Err_Code;
  logic                     o_Overrun;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Frame_Ready,
    output o_Frame_Valid, o_Cmd, o_Len, o_Payload, o_Frame_Err, o_Err_Code, o_Overrun
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Frame_Ready,
    input  o_Frame_Valid, o_Cmd, o_Len, o_Payload, o_Frame_Err, o_Err_Code, o_Overrun
  );
endinterface

// File: rtl/uart_cmd_deframer.sv
// uart_cmd_deframer
//   Assembles command frames (SYNC, CMD, LEN, LEN payload bytes, XOR checksum)
//   from the UART receiver's one-cycle byte strobe and presents validated frames
//   on a valid/ready handshake. Malformed or stalled frames are dropped and
//   flagged with a cause code; bytes arriving while a frame is held are dropped
//   and flagged as overrun.
//   Ports:
//     i_Clock : system clock
//     i_Reset : asynchronous active-high reset (released synchronously inside)
//     bus     : uart_cmd_deframer_if.slave, byte input / frame output / flags
module uart_cmd_deframer #(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1740
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  uart_cmd_deframer_if.slave bus
);
  localparam int         TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [1:0]               r_rst_sync;
  logic                     w_rst;
  logic [7:0]               r_cmd;
  logic [7:0]               r_len;
  logic [7:0]               r_idx;
  logic [7:0]               r_csum;
  logic [8*MAX_PAYLOAD-1:0] r_payload;
  logic [TW-1:0]            r_tmo_cnt;
  logic                     r_valid;
  logic                     r_err;
  logic [1:0]               r_err_code;
  logic                     r_overrun;
  logic                     w_timed;
  logic                     w_expire;
  logic                     w_start;
  logic                     w_cmd_we;
  logic                     w_len_we;
  logic                     w_pay_we;
  logic                     w_frame_ok;
  logic                     w_release;
  logic                     w_err;
  logic [1:0]               w_err_code;
  logic                     w_overrun;

  // Reset asserts immediately but is released on a clock edge, two flops deep.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end
  assign w_rst = r_rst_sync[1];

  // The idle timer only matters while a frame is partially received.
  assign w_timed   = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  // A byte in the expiry cycle wins over the timeout.
  assign w_expire  = w_timed && !bus.i_Rx_DV && (r_tmo_cnt == TW'(TIMEOUT_CLKS));
  // Every byte in HOLD is dropped, including the handshake cycle.
  assign w_overrun = (r_state == S_HOLD) && bus.i_Rx_DV;

  // State register.
  always_ff @(posedge i_Clock or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-byte datapath strobes.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_cmd_we   = 1'b0;
    w_len_we   = 1'b0;
    w_pay_we   = 1'b0;
    w_frame_ok = 1'b0;
    w_release  = 1'b0;
    w_err      = 1'b0;
    w_err_code = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
          w_start = 1'b1;
          w_next  = S_CMD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus.i_Rx_DV) begin
          w_cmd_we = 1'b1;
          w_next   = S_LEN;
        end else if (w_expire) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_next     = S_IDLE;
        end else begin
          w_next = S_CMD;
        end
      end
      S_LEN: begin
        if (bus.i_Rx_DV) begin
          if ((bus.i_Rx_Byte == 8'd0) || (bus.i_Rx_Byte > MAX_LEN)) begin
            w_err      = 1'b1;
            w_err_code = 2'd1;
            w_next     = S_IDLE;
          end else begin
            w_len_we = 1'b1;
            w_next   = S_PAYLOAD;
          end
        end else if (w_expire) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_next     = S_IDLE;
        end else begin
          w_next = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (bus.i_Rx_DV) begin
          w_pay_we = 1'b1;
          if (r_idx == (r_len - 8'd1)) begin
            w_next = S_CHECK;
          end else begin
            w_next = S_PAYLOAD;
          end
        end else if (w_expire) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_next     = S_IDLE;
        end else begin
          w_next = S_PAYLOAD;
        end
      end
      S_CHECK: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == r_csum) begin
            w_frame_ok = 1'b1;
            w_next     = S_HOLD;
          end else begin
            w_err      = 1'b1;
            w_err_code = 2'd2;
            w_next     = S_IDLE;
          end
        end else if (w_expire) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
          w_next     = S_IDLE;
        end else begin
          w_next = S_CHECK;
        end
      end
      S_HOLD: begin
        if (bus.i_Frame_Ready) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Frame datapath, idle timer and registered flags.
  always_ff @(posedge i_Clock or posedge w_rst) begin
    if (w_rst) begin
      r_cmd      <= 8'd0;
      r_len      <= 8'd0;
      r_idx      <= 8'd0;
      r_csum     <= 8'd0;
      r_payload  <= '0;
      r_tmo_cnt  <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_err     <= w_err;
      r_overrun <= w_overrun;
      if (w_err) begin
        r_err_code <= w_err_code;
      end
      if (!w_timed || bus.i_Rx_DV || w_expire) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_start) begin
        r_payload <= '0;
        r_csum    <= 8'd0;
      end
      if (w_cmd_we) begin
        r_cmd  <= bus.i_Rx_Byte;
        r_csum <= bus.i_Rx_Byte;
      end
      if (w_len_we) begin
        r_len  <= bus.i_Rx_Byte;
        r_csum <= r_csum ^ bus.i_Rx_Byte;
        r_idx  <= 8'd0;
      end
      if (w_pay_we) begin
        r_csum <= r_csum ^ bus.i_Rx_Byte;
        r_idx  <= r_idx + 8'd1;
      end
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
        if (w_pay_we && (r_idx == 8'(k))) begin
          r_payload[8*k +: 8] <= bus.i_Rx_Byte;
        end
      end
      if (w_frame_ok) begin
        r_valid <= 1'b1;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_Frame_Valid = r_valid;
  assign bus.o_Cmd         = r_cmd;
  assign bus.o_Len         = r_len;
  assign bus.o_Payload     = r_payload;
  assign bus.o_Frame_Err   = r_err;
  assign bus.o_Err_Code    = r_err_code;
  assign bus.o_Overrun     = r_overrun;
endmodule

// File: tb/tb_uart_cmd_deframer.sv
// tb_uart_cmd_deframer
//   Directed bench for uart_cmd_deframer. Expected frames and error codes are
//   queued as stimulus is sent and compared when the deframer hands a frame
//   over or pulses its error flag; timing and stability are checked inline.
module tb_uart_cmd_deframer;
  localparam int         MAX_PAYLOAD = 16;
  localparam logic [7:0] SYNC        = 8'hA5;
  localparam int         TIMEOUT     = 1740;
  localparam int         PW          = 8 * MAX_PAYLOAD;

  typedef struct {
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [PW-1:0] pay;
  } frame_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  int       checks = 0;
  int       errors = 0;
  frame_t   exp_frames[$];
  logic [1:0] exp_errs[$];

  uart_cmd_deframer_if #(.MAX_PAYLOAD(MAX_PAYLOAD)) bus();

  uart_cmd_deframer #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"},   PW'(bus.o_Frame_Valid), '0);
    chk({tag, "_err"},     PW'(bus.o_Frame_Err),   '0);
    chk({tag, "_code"},    PW'(bus.o_Err_Code),    '0);
    chk({tag, "_overrun"}, PW'(bus.o_Overrun),     '0);
    chk({tag, "_cmd"},     PW'(bus.o_Cmd),         '0);
    chk({tag, "_len"},     PW'(bus.o_Len),         '0);
    chk({tag, "_payload"}, bus.o_Payload,          '0);
  endtask

  // One byte strobe; called and returns 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(posedge clk);
    #1;
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [PW-1:0] pay, input logic [7:0] csum_xor,
                            input bit expect_frame);
    logic [7:0] cs;
    frame_t     f;
    cs = cmd ^ len;
    for (int k = 0; k < int'(len); k++) cs = cs ^ pay[8*k +: 8];
    if (csum_xor != 8'h00) begin
      exp_errs.push_back(2'd2);
    end else if (expect_frame) begin
      f.cmd = cmd;
      f.len = len;
      f.pay = pay;
      exp_frames.push_back(f);
    end
    send(SYNC);
    send(cmd);
    send(len);
    for (int k = 0; k < int'(len); k++) send(pay[8*k +: 8]);
    chk("pre_csum_valid", PW'(bus.o_Frame_Valid), '0);
    send(cs ^ csum_xor);
  endtask

  // Scoreboard side: compare on handshake and on error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_Frame_Valid && bus.i_Frame_Ready) begin
        chk("frame_pending", PW'(exp_frames.size() > 0), PW'(1));
        if (exp_frames.size() > 0) begin
          frame_t f;
          f = exp_frames.pop_front();
          chk("frame_cmd", PW'(bus.o_Cmd), PW'(f.cmd));
          chk("frame_len", PW'(bus.o_Len), PW'(f.len));
          chk("frame_payload", bus.o_Payload, f.pay);
        end
      end
      if (bus.o_Frame_Err) begin
        chk("err_pending", PW'(exp_errs.size() > 0), PW'(1));
        if (exp_errs.size() > 0) begin
          chk("err_code", PW'(bus.o_Err_Code), PW'(exp_errs.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_Rx_DV       = 1'b0;
    bus.i_Rx_Byte     = 8'h00;
    bus.i_Frame_Ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;
    idle(3);
    all_zero("post_reset");

    // Test 1: good frame, consumer always ready, one valid cycle.
    bus.i_Frame_Ready = 1'b1;
    send_frame(8'h10, 8'd3, PW'(24'h332211), 8'h00, 1'b1);
    chk("t1_valid_latency", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);
    chk("t1_valid_one_cycle", PW'(bus.o_Frame_Valid), '0);

    // Test 2: bad checksum (00 instead of 12), then the same frame good.
    send_frame(8'h01, 8'd2, PW'(16'hBBAA), 8'h12, 1'b0);
    chk("t2_err_pulse", PW'(bus.o_Frame_Err), PW'(1));
    chk("t2_no_valid", PW'(bus.o_Frame_Valid), '0);
    idle(1);
    chk("t2_err_clear", PW'(bus.o_Frame_Err), '0);
    chk("t2_code_hold", PW'(bus.o_Err_Code), PW'(2));
    send_frame(8'h01, 8'd2, PW'(16'hBBAA), 8'h00, 1'b1);
    chk("t2_good_valid", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);

    // Test 3: LEN of 0 and of MAX_PAYLOAD+1, stray bytes ignored, length boundaries.
    exp_errs.push_back(2'd1);
    send(SYNC); send(8'h01); send(8'h00);
    chk("t3_len0_err", PW'(bus.o_Frame_Err), PW'(1));
    send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h13);
    idle(2);
    chk("t3_ignored_valid", PW'(bus.o_Frame_Valid), '0);
    exp_errs.push_back(2'd1);
    send(SYNC); send(8'h01); send(8'(MAX_PAYLOAD + 1));
    chk("t3_lenmax_err", PW'(bus.o_Frame_Err), PW'(1));
    idle(1);
    send_frame(8'h7E, 8'(MAX_PAYLOAD), 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'h00, 1'b1);
    chk("t3_len16_valid", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);
    send_frame(SYNC, 8'd1, PW'(SYNC), 8'h00, 1'b1);
    chk("t3_len1_valid", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);

    // Test 4: timeout after TIMEOUT idle clocks; bytes at the limit survive.
    exp_errs.push_back(2'd3);
    send(SYNC); send(8'h01);
    idle(TIMEOUT);
    chk("t4_before_expiry", PW'(bus.o_Frame_Err), '0);
    idle(1);
    chk("t4_expiry_err", PW'(bus.o_Frame_Err), PW'(1));
    chk("t4_expiry_code", PW'(bus.o_Err_Code), PW'(3));
    idle(1);
    chk("t4_err_clear", PW'(bus.o_Frame_Err), '0);
    chk("t4_code_hold", PW'(bus.o_Err_Code), PW'(3));
    begin
      frame_t f;
      f.cmd = 8'h01; f.len = 8'd2; f.pay = PW'(16'hBBAA);
      exp_frames.push_back(f);
    end
    send(SYNC); send(8'h01); send(8'h02);
    idle(TIMEOUT - 1);
    send(8'hAA);
    idle(TIMEOUT);
    send(8'hBB);
    idle(TIMEOUT - 1);
    send(8'h12);
    chk("t4_slow_valid", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);

    // Test 5: held frame, bytes dropped with overrun pulses, then handshake.
    bus.i_Frame_Ready = 1'b0;
    send_frame(8'h5A, 8'd2, PW'(16'hBEEF), 8'h00, 1'b1);
    idle(1);
    chk("t5_hold_valid", PW'(bus.o_Frame_Valid), PW'(1));
    send(SYNC);
    chk("t5_overrun1", PW'(bus.o_Overrun), PW'(1));
    idle(1);
    chk("t5_overrun1_clear", PW'(bus.o_Overrun), '0);
    send(8'h55);
    chk("t5_overrun2", PW'(bus.o_Overrun), PW'(1));
    chk("t5_cmd_stable", PW'(bus.o_Cmd), PW'(8'h5A));
    chk("t5_len_stable", PW'(bus.o_Len), PW'(2));
    chk("t5_payload_stable", bus.o_Payload, PW'(16'hBEEF));
    chk("t5_valid_stable", PW'(bus.o_Frame_Valid), PW'(1));
    idle(1);
    bus.i_Frame_Ready = 1'b1;
    send(8'h77);
    chk("t5_valid_drop", PW'(bus.o_Frame_Valid), '0);
    chk("t5_overrun_hs", PW'(bus.o_Overrun), PW'(1));
    idle(2);

    // Test 6: reset mid-payload and mid-hold, then a good frame.
    send(SYNC); send(8'h10); send(8'h03); send(8'h11);
    #1 rst = 1'b1;
    #1 all_zero("t6_payload_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    bus.i_Frame_Ready = 1'b0;
    send_frame(8'h22, 8'd1, PW'(8'h44), 8'h00, 1'b0);
    chk("t6_hold_valid", PW'(bus.o_Frame_Valid), PW'(1));
    #2 rst = 1'b1;
    #1 all_zero("t6_hold_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    bus.i_Frame_Ready = 1'b1;
    send_frame(8'h10, 8'd3, PW'(24'h332211), 8'h00, 1'b1);
    chk("t6_post_valid", PW'(bus.o_Frame_Valid), PW'(1));
    idle(3);

    chk("frames_left", PW'(exp_frames.size()), '0);
    chk("errs_left", PW'(exp_errs.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
